// File: rtl/tsp_hex_display_if.sv
// ---------------------------------------------------------------------------
// tsp_hex_display_if
//
// Purpose:
//   Valid/ready handshake between the TSP solver core (the producer) and the
//   hex display stage (the consumer). It carries one unsigned result word per
//   transfer.
//
// Signals:
//   in_valid  producer -> consumer  a value is present on in_value
//   in_ready  consumer -> producer  consumer can take a value this cycle
//   in_value  producer -> consumer  unsigned binary value, WIDTH bits
//
// Modports:
//   master  the producer side (solver core or testbench)
//   slave   the consumer side (tsp_hex_display)
// ---------------------------------------------------------------------------
interface tsp_hex_display_if #(
  parameter int WIDTH = 20
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_value;

  // The producer drives the data and qualifier, and watches ready.
  modport master (
    output in_valid,
    output in_value,
    input  in_ready
  );

  // The display stage watches the data and qualifier, and drives ready.
  modport slave (
    input  in_valid,
    input  in_value,
    output in_ready
  );

endinterface

// File: rtl/tsp_hex_display.sv
// ---------------------------------------------------------------------------
// tsp_hex_display
//
// Purpose:
//   Display stage of the TSP solver. It takes one binary result per handshake
//   and converts it to BCD with a sequential shift-add-3 (double-dabble)
//   engine, running one iteration per clock. It then latches the digits onto
//   the board's active-low seven-segment displays. Digits above the most
//   significant nonzero digit are blanked. A value that does not fit in
//   DIGITS decimal digits shows dashes on every digit.
//
// Parameters:
//   WIDTH   bit width of the incoming value (at most 64)
//   DIGITS  number of decimal digits shown, 1..6; HEX outputs above
//           DIGITS-1 stay blank
//
// Ports:
//   clk         system clock
//   nrst        synchronous, active-low reset
//   bus         slave side of the valid/ready handshake (in_valid,
//               in_ready, in_value)
//   busy        high while a conversion or latch is in progress
//   disp_valid  high once at least one value has been latched since reset
//   HEX0..HEX5  segment drive, bit0 = a ... bit6 = g, active-low;
//               HEX0 is the least significant digit
// ---------------------------------------------------------------------------
module tsp_hex_display #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6
) (
  input  logic               clk,
  input  logic               nrst,
  tsp_hex_display_if.slave   bus,
  output logic               busy,
  output logic               disp_valid,
  output logic [6:0]         HEX0,
  output logic [6:0]         HEX1,
  output logic [6:0]         HEX2,
  output logic [6:0]         HEX3,
  output logic [6:0]         HEX4,
  output logic [6:0]         HEX5
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Largest value that still fits in DIGITS decimal digits. It is computed at
  // elaboration time in 64 bits, so the overflow compare never loses bits for
  // any legal WIDTH.
  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int k = 0; k < n; k++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  localparam longint unsigned MAX_VAL = pow10(DIGITS) - 64'd1;

  // Active-low segment patterns. Codes above 9 cannot come out of a
  // non-overflowing conversion, so they map to blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LATCH   = 2'd2
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    bin_r;
  logic [BW-1:0]       bcd_r;
  logic [CW-1:0]       cnt;
  logic                ovf_r;
  logic                in_ready_r;
  logic [6:0]          hex_r [6];

  logic [63:0]         in_ext;
  logic                ovf_next;
  logic [BW-1:0]       bcd_adj;
  logic [BW+WIDTH-1:0] shift_next;
  logic [23:0]         bcd_full;
  logic [6:0]          next_hex [6];
  logic [3:0]          digit;
  logic                seen;

  // The overflow test is made on the raw input at accept time, so the BCD
  // engine never has to represent an out-of-range number. Once ovf is set,
  // whatever falls off the top of the BCD register is irrelevant.
  assign in_ext   = 64'(bus.in_value);
  assign ovf_next = (in_ext > MAX_VAL);

  // First half of a double-dabble iteration: every BCD digit of 5 or more
  // gets 3 added. The following shift then carries it correctly into the
  // next decade.
  always_comb begin
    bcd_adj = bcd_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
      end
    end
  end

  // Second half: shift {BCD, binary} left by one. The binary MSB enters BCD
  // bit 0, and the top BCD bit falls off.
  assign shift_next = {bcd_adj, bin_r} << 1;

  // The BCD register is widened to the full six-digit span so the decode
  // loop below can index every display position without range trouble when
  // DIGITS is less than 6.
  assign bcd_full = 24'(bcd_r);

  // Display decode, built from the finished BCD value for the LATCH cycle.
  // Scanning from the top digit down, 'seen' goes high at the first nonzero
  // digit. Any digit before that point is a leading zero and is blanked,
  // except HEX0, which always shows a digit so that zero reads as "0".
  // Overflow replaces every active digit with a dash.
  always_comb begin
    seen  = 1'b0;
    digit = 4'd0;
    for (int i = 5; i >= 0; i--) begin
      next_hex[i] = SEG_BLANK;
      if (i < DIGITS) begin
        digit = bcd_full[4*i +: 4];
        if (digit != 4'd0) begin
          seen = 1'b1;
        end
        if (ovf_r) begin
          next_hex[i] = SEG_DASH;
        end else if (seen || (i == 0)) begin
          next_hex[i] = seg7(digit);
        end
      end
    end
  end

  // Control FSM and datapath registers.
  // in_ready is a register. It is low while reset is held and rises on the
  // first clock after release, so the accept condition never depends on
  // nrst combinationally. A value is captured only on an IDLE edge where
  // in_ready and in_valid are both high. After that, CONVERT runs exactly
  // WIDTH iterations and does not look at in_value again. LATCH copies the
  // decoded digits into the HEX registers, which then hold until the next
  // LATCH or reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      bin_r      <= '0;
      bcd_r      <= '0;
      cnt        <= '0;
      ovf_r      <= 1'b0;
      in_ready_r <= 1'b0;
      busy       <= 1'b0;
      disp_valid <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        hex_r[i] <= SEG_BLANK;
      end
    end else begin
      case (state)
        IDLE: begin
          in_ready_r <= 1'b1;
          if (in_ready_r && bus.in_valid) begin
            bin_r      <= bus.in_value;
            bcd_r      <= '0;
            cnt        <= '0;
            ovf_r      <= ovf_next;
            in_ready_r <= 1'b0;
            busy       <= 1'b1;
            state      <= CONVERT;
          end
        end

        CONVERT: begin
          bcd_r <= shift_next[BW+WIDTH-1:WIDTH];
          bin_r <= shift_next[WIDTH-1:0];
          if (cnt == CW'(WIDTH - 1)) begin
            state <= LATCH;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        LATCH: begin
          for (int i = 0; i < 6; i++) begin
            hex_r[i] <= next_hex[i];
          end
          disp_valid <= 1'b1;
          busy       <= 1'b0;
          in_ready_r <= 1'b1;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_r;

  assign HEX0 = hex_r[0];
  assign HEX1 = hex_r[1];
  assign HEX2 = hex_r[2];
  assign HEX3 = hex_r[3];
  assign HEX4 = hex_r[4];
  assign HEX5 = hex_r[5];

endmodule

// File: tb/tb_tsp_hex_display.sv
// ---------------------------------------------------------------------------
// tb_tsp_hex_display
//
// Purpose:
//   Self-checking bench for tsp_hex_display with WIDTH=20 and DIGITS=6.
//   Every value driven into the block pushes its expected display onto a
//   scoreboard queue. That expected display comes from a decimal reference
//   model (divide and modulo by ten, with blanking and overflow rules). The
//   entry is popped and compared when the block finishes its LATCH.
// ---------------------------------------------------------------------------
module tb_tsp_hex_display;

  localparam int WIDTH  = 20;
  localparam int DIGITS = 6;
  localparam int LAT    = WIDTH + 1;

  typedef struct {
    string       tag;
    logic [41:0] hex;
  } exp_t;

  logic        clk;
  logic        nrst;
  logic        busy;
  logic        disp_valid;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [41:0] hex_all;

  exp_t        sb [$];
  int          n_checks;
  int          n_fail;
  int          edge_cnt;
  logic [41:0] last_hex;

  tsp_hex_display_if #(.WIDTH(WIDTH)) bus ();

  tsp_hex_display #(
    .WIDTH (WIDTH),
    .DIGITS(DIGITS)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .bus       (bus),
    .busy      (busy),
    .disp_valid(disp_valid),
    .HEX0      (hex0),
    .HEX1      (hex1),
    .HEX2      (hex2),
    .HEX3      (hex3),
    .HEX4      (hex4),
    .HEX5      (hex5)
  );

  assign hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter, used to measure accept-to-display latency.
  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference segment encoding, written straight from the digit table.
  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Decimal model of the whole display. The remaining quotient t equals
  // value / 10^i. If it is zero above HEX0, the digit is a leading zero and
  // shows blank.
  function automatic logic [41:0] model_hex(input longint unsigned v);
    logic [41:0]     r;
    longint unsigned t;
    longint unsigned maxv;
    maxv = 1;
    for (int i = 0; i < DIGITS; i++) maxv = maxv * 10;
    maxv = maxv - 1;
    r = {6{7'h7F}};
    t = v;
    for (int i = 0; i < 6; i++) begin
      if (i < DIGITS) begin
        if (v > maxv)
          r[7*i +: 7] = 7'h3F;
        else if (i == 0 || t != 0)
          r[7*i +: 7] = ref_seg(int'(t % 10));
      end
      t = t / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for an accept edge: in_ready high before an edge while
  // in_valid is held high.
  task automatic wait_accept(output int acc_edge, output bit ok);
    bit rdy;
    ok       = 1'b0;
    acc_edge = 0;
    for (int i = 0; i < 64; i++) begin
      rdy = bus.in_ready;
      tick();
      if (rdy) begin
        ok       = 1'b1;
        acc_edge = edge_cnt;
        break;
      end
    end
  endtask

  task automatic apply_stimulus(input logic [WIDTH-1:0] v, input string tag,
                                input bit hold, output int acc_edge,
                                output bit ok);
    exp_t e;
    e.tag = tag;
    e.hex = model_hex(longint'(v));
    sb.push_back(e);
    bus.in_value = v;
    bus.in_valid = 1'b1;
    wait_accept(acc_edge, ok);
    if (!hold) bus.in_valid = 1'b0;
    check_val({tag, " accept"}, 64'(ok), 64'd1);
    if (!ok && sb.size() > 0) e = sb.pop_back();
  endtask

  // Wait (bounded) for busy to drop, then check latency and the display
  // against the oldest scoreboard entry.
  task automatic check_output(input int acc_edge);
    exp_t e;
    bit   done;
    done = 1'b0;
    for (int i = 0; i < LAT + 8; i++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    if (sb.size() == 0) begin
      check_val("scoreboard entry present", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    check_val({e.tag, " done"}, 64'(done), 64'd1);
    check_val({e.tag, " latency"}, 64'(edge_cnt - acc_edge), 64'(LAT));
    check_val({e.tag, " hex"}, 64'(hex_all), 64'(e.hex));
    check_val({e.tag, " disp_valid"}, 64'(disp_valid), 64'd1);
    check_val({e.tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    last_hex = e.hex;
  endtask

  task automatic run_value(input logic [WIDTH-1:0] v, input string tag);
    int a;
    bit ok;
    apply_stimulus(v, tag, 1'b0, a, ok);
    if (ok) check_output(a);
  endtask

  initial begin
    exp_t        e;
    int          a1, a2;
    bit          ok1, ok2;
    logic [WIDTH-1:0] rv;

    n_checks     = 0;
    n_fail       = 0;
    last_hex     = {6{7'h7F}};
    nrst         = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_value = 20'd5;

    // Reset for three edges with in_valid asserted; it must be ignored.
    repeat (3) tick();
    check_val("reset hex", 64'(hex_all), 64'({6{7'h7F}}));
    check_val("reset disp_valid", 64'(disp_valid), 64'd0);
    check_val("reset busy", 64'(busy), 64'd0);
    bus.in_valid = 1'b0;
    nrst         = 1'b1;
    tick();
    check_val("post-reset in_ready", 64'(bus.in_ready), 64'd1);
    check_val("post-reset busy", 64'(busy), 64'd0);
    check_val("post-reset hex", 64'(hex_all), 64'({6{7'h7F}}));

    // Directed values, including blanking and overflow boundaries.
    run_value(20'd123456, "v123456");
    run_value(20'd0, "v0");
    run_value(20'd42, "v42");
    run_value(20'd1000000, "v1000000");
    run_value(20'd10, "v10");
    run_value(20'd100000, "v100000");
    run_value(20'hFFFFF, "vmax");
    for (int i = 0; i < 4; i++) begin
      rv = WIDTH'($urandom_range(1048575, 0));
      $display("[TB] random value %0d", rv);
      run_value(rv, "vrand");
    end

    // Back-to-back: in_valid held high; in_value changes during busy.
    apply_stimulus(20'd7, "b2b_first", 1'b1, a1, ok1);
    e.tag = "b2b_second";
    e.hex = model_hex(64'd999999);
    sb.push_back(e);
    repeat (3) tick();
    bus.in_value = 20'd999999;
    if (ok1) check_output(a1);
    wait_accept(a2, ok2);
    check_val("b2b second accept", 64'(ok2), 64'd1);
    check_val("b2b accept spacing", 64'(a2 - a1), 64'(LAT + 1));
    repeat (2) tick();
    bus.in_value = 20'd123;
    bus.in_valid = 1'b0;
    if (ok2) check_output(a2);
    else if (sb.size() > 0) e = sb.pop_front();

    // Reset in the middle of a conversion discards everything.
    apply_stimulus(20'd555555, "rst_mid", 1'b0, a1, ok1);
    repeat (10) tick();
    check_val("rst_mid hold hex", 64'(hex_all), 64'(last_hex));
    check_val("rst_mid busy", 64'(busy), 64'd1);
    nrst = 1'b0;
    tick();
    if (ok1 && sb.size() > 0) e = sb.pop_back();
    check_val("rst_mid hex", 64'(hex_all), 64'({6{7'h7F}}));
    check_val("rst_mid disp_valid", 64'(disp_valid), 64'd0);
    check_val("rst_mid busy after", 64'(busy), 64'd0);
    nrst = 1'b1;
    tick();
    check_val("rst_mid in_ready", 64'(bus.in_ready), 64'd1);
    run_value(20'd8, "v8");

    check_val("scoreboard empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
